instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the Risco-5 core: owns the program counter, issues single-outstanding instruction reads to instruction memory and presents each fetched word, with its PC, in a one-entry output register to the decode stage, where opcode decode and immediate generation consume it. Accepts branch/jump redirects from execute and flushes wrong-path fetches. One instruction per cycle with a zero-wait memory.

## Interface
- RESET_VECTOR, 32'h00000000: PC of the first fetch after reset.
- NOP_WORD, 32'h00000013: value of `instruction` while invalid (addi x0,x0,0).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept the held instruction this cycle.
- redirect  in  1  taken branch/jump/trap; has priority over everything except reset.
- redirect_pc  in  32  target PC, sampled when redirect=1.
- mem_rd  out  1  read request to instruction memory.
- mem_addr  out  32  word address of the request (bits [1:0] always 00).
- mem_ack  in  1  read data valid; may arrive in the same cycle as mem_rd or later.
- mem_data  in  32  instruction word, valid when mem_ack=1.
- instr_valid  out  1  `instruction`/`instr_pc` hold a fetched word.
- instruction  out  32  fetched word.
- instr_pc  out  32  PC of `instruction`.
- misaligned_fault  out  1  redirect target not word aligned (see Configuration).

## Operation
- States: IDLE, REQ, DISCARD. Registers: pc, state, instr_valid, instruction, instr_pc, fault.
- Reset: state=IDLE, pc=RESET_VECTOR, instr_valid=0, instruction=NOP_WORD, instr_pc=0, misaligned_fault=0. mem_rd=0 in IDLE.
- IDLE -> REQ on the next edge, unless the fault is set.
- Slot handshake: the output word is consumed in a cycle where instr_valid=1 and stall=0. slot_free = !instr_valid || !stall.
- REQ: a new request starts only in a cycle with slot_free=1. mem_rd=1, mem_addr=pc. Once raised, mem_rd and mem_addr hold stable until mem_ack, regardless of stall.
- On mem_ack in REQ (no redirect): instruction<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4. Wrap-around: pc is 32-bit modulo, so 32'hFFFFFFFC+4 = 0.
- Consumption without a new ack clears instr_valid. While stall=1 and instr_valid=1, all output registers hold.
- Redirect in cycle t: pc<=redirect_pc, instr_valid<=0, instruction<=NOP_WORD. Any ack in cycle t is dropped. If a request is outstanding and not acked in t, go to DISCARD. Otherwise go to REQ.
- DISCARD: mem_rd stays 1 with the old address until mem_ack, and the data is dropped. Then go to REQ and fetch from the new pc. A redirect during DISCARD updates pc and stays in DISCARD.
- Simultaneous redirect and stall: redirect wins, and the held word is flushed.

## Timing
- Output registers update on the rising clk edge. mem_rd is combinational from state, instr_valid and stall.
- Fetch latency: data acked in cycle t is visible on instruction/instr_valid in cycle t+1.
- Zero-wait memory, stall=0: one new instruction per cycle.
- First mem_rd is asserted in the second cycle after rst_n rises.
- Redirect in t with an idle bus: mem_rd for redirect_pc in t+1, and the instruction is valid in t+2 with a zero-wait memory.
- Reset assertion mid-request immediately forces the reset values. The memory must tolerate an abandoned request.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=00 sets misaligned_fault on the next edge, clears instr_valid and forces state to IDLE with no further requests.
  - An outstanding request is still completed (DISCARD) before IDLE.
  - The fault is cleared only by an aligned redirect or by reset.
- Undefined: redirect_pc[1:0] is ignored (forced to 00) and misaligned_fault is tied to 0.

## Test plan
- Reset, zero-wait memory returning addr^32'hA5A5A5A5, stall=0 -> instr_pc 0,4,8,… on consecutive cycles starting in cycle 2; misaligned_fault=0.
- stall=1 for 3 cycles with instruction at PC 0x8 held -> instruction and instr_pc constant and mem_rd=0 after the slot fills; the word at 0xC follows the cycle after stall drops.
- Memory with 3-cycle ack latency, redirect to 0x100 one cycle after mem_rd for 0x10 rises -> mem_addr stays 0x10 until ack, that data is never presented, and the next presented instr_pc is 0x100.
- Redirect and mem_ack in the same cycle -> the acked word is dropped; the next request is at redirect_pc.
- pc set to 32'hFFFFFFFC by redirect -> next instr_pc sequence is FFFFFFFC, 00000000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misaligned_fault=1 next cycle and no mem_rd; an aligned redirect to 0x200 clears the fault and resumes fetching at 0x200.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage for the Risco-5 core: PC ownership, single-outstanding
// instruction-memory reads, a one-entry output slot to decode, and
// redirect handling with flushing of wrong-path fetches.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap).
module instruction_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        misaligned_fault
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_WORD     = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_BYTES   = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic            pending;
  logic            slot_free;
  logic            ack_ok;
  logic            fault;
  logic            target_bad;
  logic [XLEN-1:0] target_pc;

  // Redirect targets are always word aligned in the PC; low bits only feed the trap.
  assign target_pc = redirect_pc & ALIGN_MASK;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_bad = (redirect_pc[1:0] != 2'b00);

  // Sticky misaligned-target fault, cleared by an aligned redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (redirect) begin
      fault <= target_bad;
    end
  end
`else
  assign target_bad = 1'b0;
  assign fault      = 1'b0;
`endif

  assign misaligned_fault = fault;

  // Address held stable while a request is outstanding, otherwise the live PC.
  assign mem_addr  = pending ? req_addr : pc;
  assign slot_free = !instr_valid || !stall;
  assign ack_ok    = mem_rd && mem_ack;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and memory request.
  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    case (state)
      IDLE: begin
        if (!fault) state_next = REQ;
      end
      REQ: begin
        mem_rd = pending || slot_free;
      end
      DISCARD: begin
        mem_rd = 1'b1;
        if (mem_ack) state_next = fault ? IDLE : REQ;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) begin
      if (mem_rd && !mem_ack) state_next = DISCARD;
      else if (target_bad)    state_next = IDLE;
      else                    state_next = REQ;
    end
  end

  // Outstanding-request tracking and captured request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      req_addr <= RESET_VECTOR;
    end else begin
      pending <= mem_rd && !mem_ack;
      if (mem_rd && !pending) req_addr <= pc;
    end
  end

  // PC and output slot: redirect flushes, ack fills, consumption empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      instr_valid <= 1'b0;
      instruction <= NOP_WORD;
      instr_pc    <= '0;
    end else if (redirect) begin
      pc          <= target_pc;
      instr_valid <= 1'b0;
      instruction <= NOP_WORD;
    end else if (state == REQ && ack_ok) begin
      instruction <= mem_data;
      instr_pc    <= mem_addr;
      instr_valid <= 1'b1;
      pc          <= XLEN'(pc + WORD_BYTES);
    end else if (instr_valid && !stall) begin
      instr_valid <= 1'b0;
      instruction <= NOP_WORD;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed phases push expected PCs,
// a negedge monitor pops and compares every word consumed by decode.
module tb_instruction_fetch;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] XOR_PAT  = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        misaligned_fault;

  int ncmp = 0;
  int nerr = 0;
  int latency = 0;
  int lat_cnt;
  logic [31:0] sb[$];

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instr_valid(instr_valid),
    .instruction(instruction), .instr_pc(instr_pc),
    .misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  // Memory model: data = addr ^ pattern, ack after `latency` waiting cycles.
  assign mem_ack  = mem_rd && (lat_cnt >= latency);
  assign mem_data = mem_addr ^ XOR_PAT;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_cnt <= 0;
    else if (mem_rd && !mem_ack) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each word consumed by decode is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && stall === 1'b0) begin
      if (sb.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_word: got pc %h with empty scoreboard", instr_pc);
      end else begin
        logic [31:0] epc;
        epc = sb.pop_front();
        check("instr_pc", instr_pc, epc);
        check("instruction", instruction, epc ^ XOR_PAT);
        check("fault_while_valid", 32'(misaligned_fault), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let decode consume until the scoreboard empties, then stall and settle.
  task automatic drain();
    int n = 0;
    stall = 1'b0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL drain_timeout: %0d words still expected", sb.size());
      sb.delete();
    end
    stall = 1'b1;
    repeat (6) tick();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) tick();

    // Reset values.
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", instruction, NOP_WORD);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_fault", 32'(misaligned_fault), 32'd0);

    // Sequential fetch from the reset vector.
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_cycle_mem_rd", 32'(mem_rd), 32'd0);
    tick();
    check("second_cycle_mem_rd", 32'(mem_rd), 32'd1);
    check("second_cycle_addr", mem_addr, 32'h0);
    drain();

    // Stall holds the word at 0x8 with no new requests.
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", instr_pc, 32'h8);
      check("stall_instr", instruction, 32'h8 ^ XOR_PAT);
      check("stall_mem_rd", 32'(mem_rd), 32'd0);
      tick();
    end
    sb.push_back(32'h8);
    sb.push_back(32'hC);
    sb.push_back(32'h10);
    drain();

    // Slow memory: redirect while the 0x10 request is outstanding.
    latency = 3;
    do_redirect(32'h10);
    check("slow_req_rd", 32'(mem_rd), 32'd1);
    check("slow_req_addr", mem_addr, 32'h10);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    tick();
    do_redirect(32'h100);
    check("discard_rd_a", 32'(mem_rd), 32'd1);
    check("discard_addr_a", mem_addr, 32'h10);
    tick();
    check("discard_rd_b", 32'(mem_rd), 32'd1);
    check("discard_addr_b", mem_addr, 32'h10);
    check("discard_ack_b", 32'(mem_ack), 32'd1);
    tick();
    check("after_discard_rd", 32'(mem_rd), 32'd1);
    check("after_discard_addr", mem_addr, 32'h100);
    check("after_discard_valid", 32'(instr_valid), 32'd0);
    drain();

    // Redirect coinciding with an ack drops the acked word.
    do_redirect(32'h300);
    n = 0;
    while (!(mem_rd && mem_ack) && n < 20) begin
      tick();
      n++;
    end
    check("ack_seen", 32'(mem_rd && mem_ack), 32'd1);
    check("ack_addr", mem_addr, 32'h300);
    sb.push_back(32'h400);
    sb.push_back(32'h404);
    do_redirect(32'h400);
    check("same_cycle_valid", 32'(instr_valid), 32'd0);
    check("same_cycle_rd", 32'(mem_rd), 32'd1);
    check("same_cycle_addr", mem_addr, 32'h400);
    drain();

    // PC wrap-around at the top of the address space.
    latency = 0;
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    do_redirect(32'hFFFF_FFFC);
    drain();

    // Misaligned redirect target.
`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h102);
    check("trap_fault", 32'(misaligned_fault), 32'd1);
    check("trap_valid", 32'(instr_valid), 32'd0);
    check("trap_mem_rd", 32'(mem_rd), 32'd0);
    stall = 1'b0;
    tick();
    tick();
    check("trap_still_idle", 32'(mem_rd), 32'd0);
    check("trap_still_fault", 32'(misaligned_fault), 32'd1);
    stall = 1'b1;
    sb.push_back(32'h200);
    sb.push_back(32'h204);
    do_redirect(32'h200);
    check("trap_cleared", 32'(misaligned_fault), 32'd0);
    check("trap_resume_addr", mem_addr, 32'h200);
    drain();
`else
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    do_redirect(32'h102);
    check("unaligned_no_fault", 32'(misaligned_fault), 32'd0);
    check("unaligned_addr", mem_addr, 32'h100);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
